// File: rtl/sim_mem_pkg.sv
// Shared types for the simulated data-cache responder.
// Holds FSM states, access-size codes and lane helpers.
package sim_mem_pkg;

  localparam int LG_CQSZ = 3;
  localparam int TAGW    = LG_CQSZ + 1;
  localparam int WBYTES  = 8;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            wena;
    logic [63:0]     addr;
    logic [2:0]      bits;
    logic [63:0]     wdat;
  } req_t;

  // low address bits that must be zero for an aligned access
  function automatic logic [2:0] sz_amask(input logic [1:0] sz);
    logic [2:0] m;
    m = 3'd0;
    unique case (sz)
      SZ_B: m = 3'd0;
      SZ_H: m = 3'd1;
      SZ_W: m = 3'd3;
      SZ_D: m = 3'd7;
    endcase
    return m;
  endfunction

  // byte enables for an access at lane 0
  function automatic logic [7:0] sz_bemask(input logic [1:0] sz);
    logic [7:0] m;
    m = 8'h00;
    unique case (sz)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0f;
      SZ_D: m = 8'hff;
    endcase
    return m;
  endfunction

  // sign- or zero-extend an LSB-justified load value
  function automatic logic [63:0] load_ext(
    input logic [63:0] r,
    input logic [1:0]  sz,
    input logic        zext
  );
    logic [63:0] v;
    v = r;
    unique case (sz)
      SZ_B: v = zext ? {56'd0, r[7:0]}
                     : {{56{r[7]}}, r[7:0]};
      SZ_H: v = zext ? {48'd0, r[15:0]}
                     : {{48{r[15]}}, r[15:0]};
      SZ_W: v = zext ? {32'd0, r[31:0]}
                     : {{32{r[31]}}, r[31:0]};
      SZ_D: v = r;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dcache_resp_mem.sv
// Backing word store for the cache responder.
// Byte-enabled synchronous write, combinational read.
module dcache_resp_mem
  import sim_mem_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  // write only the enabled byte lanes; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WBYTES; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dcache_resp.sv
// Fixed-latency data-cache responder over a simulated
// word store, with load/store/error statistics.
module dcache_resp
  import sim_mem_pkg::*;
#(
  parameter int          MEMWORDS = 4096,
  parameter logic [63:0] BASE     = 64'h8000_0000,
  parameter int          LAT      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TAGW-1:0] dcache_rqst,
  input  logic            dcache_wena,
  input  logic [63:0]     dcache_addr,
  input  logic [2:0]      dcache_bits,
  input  logic [63:0]     dcache_wdat,
  output logic [TAGW-1:0] dcache_done,
  output logic [63:0]     dcache_rdat,
  output logic [63:0]     nreads,
  output logic [63:0]     nwrites,
  output logic [63:0]     nerrs
);

  localparam int AW = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
  localparam int LAT_C = (LAT < LAT_MIN) ? LAT_MIN :
                         (LAT > LAT_MAX) ? LAT_MAX : LAT;

  state_t        state;
  state_t        nstate;
  logic [3:0]    cnt;
  req_t          req_q;
  req_t          req_in;
  req_t          cur;
  logic          commit;
  logic          misal;
  logic          inr;
  logic          we;
  logic [1:0]    sz;
  logic [2:0]    amask;
  logic [2:0]    lane;
  logic [63:0]   a_al;
  logic [63:0]   off;
  logic [63:0]   word;
  logic [63:0]   wdata;
  logic [63:0]   rdata;
  logic [63:0]   ld_val;
  logic [7:0]    be;
  logic [AW-1:0] idx;

  assign req_in = '{tag:  dcache_rqst,
                    wena: dcache_wena,
                    addr: dcache_addr,
                    bits: dcache_bits,
                    wdat: dcache_wdat};

  // LAT=1 commits straight from IDLE, before capture
  assign cur = (state == IDLE) ? req_in : req_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (dcache_rqst != '0)
              nstate = (LAT_C == 1) ? DONE : BUSY;
      BUSY: if (cnt == 4'd1) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // done pulse only while in DONE
  always_comb begin
    dcache_done = '0;
    if (state == DONE) dcache_done = req_q.tag;
  end

  // request capture and latency countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      req_q <= '0;
    end else if (state == IDLE) begin
      if (dcache_rqst != '0) begin
        req_q <= req_in;
        cnt   <= 4'(LAT_C - 1);
      end
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign commit = !rst && (nstate == DONE) &&
                  (state != DONE);

  // address decode, lane steering, load extension
  always_comb begin
    sz     = cur.bits[1:0];
    amask  = sz_amask(sz);
    misal  = |(cur.addr[2:0] & amask);
    a_al   = {cur.addr[63:3], cur.addr[2:0] & ~amask};
    off    = a_al - BASE;
    word   = off >> 3;
    inr    = (a_al >= BASE) &&
             (word < 64'(MEMWORDS));
    lane   = a_al[2:0];
    idx    = word[AW-1:0];
    be     = sz_bemask(sz) << lane;
    wdata  = cur.wdat << {lane, 3'b000};
    we     = commit && cur.wena && inr;
    ld_val = load_ext(rdata >> {lane, 3'b000},
                      sz, cur.bits[2]);
  end

  dcache_resp_mem #(
    .WORDS (MEMWORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .idx   (idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  // load result and statistics, updated on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      dcache_rdat <= '0;
      nreads      <= '0;
      nwrites     <= '0;
      nerrs       <= '0;
    end else if (commit) begin
      if (cur.wena) begin
        nwrites <= nwrites + 64'd1;
      end else begin
        nreads      <= nreads + 64'd1;
        dcache_rdat <= inr ? ld_val : 64'd0;
      end
      if (misal || !inr) nerrs <= nerrs + 64'd1;
    end
  end

endmodule

// File: tb/tb_dcache_resp.sv
// Randomized bench for dcache_resp against a byte-level
// memory model, plus fixed directed scenarios.
module tb_dcache_resp;
  import sim_mem_pkg::*;

  localparam int          MW   = 64;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          LAT  = 3;

  logic            clk;
  logic            rst;
  logic [TAGW-1:0] rqst;
  logic            wena;
  logic [63:0]     addr;
  logic [2:0]      bits;
  logic [63:0]     wdat;
  logic [TAGW-1:0] done;
  logic [63:0]     rdat;
  logic [63:0]     nr;
  logic [63:0]     nw;
  logic [63:0]     ne;

  dcache_resp #(
    .MEMWORDS (MW),
    .BASE     (BASE),
    .LAT      (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dcache_rqst (rqst),
    .dcache_wena (wena),
    .dcache_addr (addr),
    .dcache_bits (bits),
    .dcache_wdat (wdat),
    .dcache_done (done),
    .dcache_rdat (rdat),
    .nreads      (nr),
    .nwrites     (nw),
    .nerrs       (ne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [63:0]     mm [MW];
  logic [63:0]     m_rd = '0;
  logic [63:0]     m_nr = '0;
  logic [63:0]     m_nw = '0;
  logic [63:0]     m_ne = '0;
  logic [TAGW-1:0] exp_done = '0;

  int cyc = 0;
  int last_done = -100;
  int prev_done = -100;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // byte-level reference of one completed access
  task automatic model(input logic w,
                       input logic [63:0] a,
                       input logic [2:0] b,
                       input logic [63:0] d);
    int n;
    logic [63:0] al, o, v;
    bit err, inr;
    n   = 1 << b[1:0];
    err = (a % 64'(n)) != 0;
    al  = a - (a % 64'(n));
    inr = (al >= BASE) && ((al - BASE) / 8 < 64'(MW));
    if (!inr) err = 1;
    if (err) m_ne++;
    if (w) begin
      m_nw++;
      if (inr)
        for (int i = 0; i < n; i++) begin
          o = al - BASE + 64'(i);
          mm[int'(o >> 3)][int'(o[2:0])*8 +: 8] = d[i*8 +: 8];
        end
    end else begin
      m_nr++;
      v = '0;
      if (inr) begin
        for (int i = 0; i < n; i++) begin
          o = al - BASE + 64'(i);
          v[i*8 +: 8] = mm[int'(o >> 3)][int'(o[2:0])*8 +: 8];
        end
        if (!b[2] && n < 8 && v[n*8-1])
          for (int j = n*8; j < 64; j++) v[j] = 1'b1;
      end
      m_rd = v;
    end
  endtask

  task automatic model_rst();
    m_rd = '0; m_nr = '0; m_nw = '0; m_ne = '0;
  endtask

  // one compare per output on every cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("done", 64'(done), 64'(exp_done));
    chk("rdat", rdat, m_rd);
    chk("nreads", nr, m_nr);
    chk("nwrites", nw, m_nw);
    chk("nerrs", ne, m_ne);
    if (done != '0) begin
      prev_done = last_done;
      last_done = cyc;
    end
  end

  // request, junk during BUSY/DONE, model commit at LAT
  task automatic issue(input logic [TAGW-1:0] tg,
                       input logic w,
                       input logic [63:0] a,
                       input logic [2:0] b,
                       input logic [63:0] d);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rqst = tg; wena = w; addr = a; bits = b; wdat = d;
      end else if (k < LAT) begin
        rqst = TAGW'($urandom_range(1, 15));
        wena = 1'($urandom);
        addr = {$urandom, $urandom};
        bits = 3'($urandom);
        wdat = {$urandom, $urandom};
      end else begin
        rqst = '0;
      end
      if (k + 1 == LAT) begin
        model(w, a, b, d);
        exp_done = tg;
      end else begin
        exp_done = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rqst = '0;
    exp_done = '0;
    model_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [63:0] ra;
  logic [63:0] keep;

  initial begin
    rst = 1'b1;
    rqst = '0; wena = 1'b0; addr = '0;
    bits = '0; wdat = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdat", rdat, 64'd0);
    chk("rst_cnt", nr | nw | ne, 64'd0);

    for (int i = 0; i < 16; i++)
      issue(4'd1, 1'b1, BASE + 64'(8*i), 3'b011,
            (i == 0) ? 64'h0123_4567_89AB_80FF
                     : {$urandom, $urandom});
    do_reset();
    chk("rst_keep_cnt", nw, 64'd0);

    issue(4'd2, 1'b1, BASE + 64'd8, 3'd3,
          64'h1122_3344_5566_7788);
    issue(4'd3, 1'b0, BASE + 64'd8, 3'd3, 64'd0);
    chk("sd_ld_rdat", rdat, 64'h1122_3344_5566_7788);
    chk("sd_ld_nw", nw, 64'd1);
    chk("sd_ld_nr", nr, 64'd1);

    issue(4'd4, 1'b0, BASE, 3'd0, 64'd0);
    chk("lb_sext", rdat, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(4'd5, 1'b0, BASE, 3'd4, 64'd0);
    chk("lbu_zext", rdat, 64'h0000_0000_0000_00FF);

    issue(4'd6, 1'b1, BASE + 64'd6, 3'd1, 64'hABCD);
    issue(4'd7, 1'b0, BASE, 3'd3, 64'd0);
    chk("sh_lanes", rdat, 64'hABCD_4567_89AB_80FF);

    issue(4'd8, 1'b0, BASE - 64'd8, 3'd3, 64'd0);
    chk("oor_rdat", rdat, 64'd0);
    chk("oor_nerrs", ne, 64'd1);
    issue(4'd9, 1'b0, BASE + 64'd3, 3'd2, 64'd0);
    chk("mis_rdat", rdat, 64'hFFFF_FFFF_89AB_80FF);
    chk("mis_nerrs", ne, 64'd2);

    issue(4'd1, 1'b0, BASE + 64'd16, 3'd3, 64'd0);
    issue(4'd2, 1'b0, BASE + 64'd24, 3'd3, 64'd0);
    chk("b2b_gap", 64'(last_done - prev_done),
        64'(LAT + 1));

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0)
          ra = BASE - 64'($urandom_range(1, 64));
        else
          ra = BASE + 64'(MW*8) + 64'($urandom_range(0, 64));
      end else begin
        ra = BASE + 64'($urandom_range(0, 127));
      end
      issue(TAGW'($urandom_range(1, 15)),
            1'($urandom), ra, 3'($urandom),
            {$urandom, $urandom});
    end

    keep = mm[2];
    @(negedge clk);
    rqst = 4'd5; wena = 1'b1; addr = BASE + 64'd16;
    bits = 3'd3; wdat = ~keep;
    exp_done = '0;
    @(negedge clk);
    rqst = '0;
    rst = 1'b1;
    model_rst();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cnt", nr | nw | ne, 64'd0);
    issue(4'd6, 1'b0, BASE + 64'd16, 3'd3, 64'd0);
    chk("abort_mem", rdat, keep);
    chk("abort_nr", nr, 64'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
